// File: rtl/counter_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: count, limit, terminal-count and saturation registers.
// wrap_evt is combinational so a downstream channel can step in the same cycle.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_LIMIT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  count_dir_e       dir,
    input  count_mode_e      mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             limit_we,
    input  logic [WIDTH-1:0] limit_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat,
    output logic             wrap_evt
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] limit_reg;
    logic             tc_reg, tc_next;
    logic             sat_reg, sat_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            limit_reg <= WIDTH'(DEFAULT_LIMIT);
            tc_reg    <= 1'b0;
            sat_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            sat_reg   <= sat_next;
            if (limit_we) begin
                limit_reg <= limit_val;
            end
        end
    end

    // Load clamps against the limit currently in force, even if a new limit
    // is being written in the same cycle.
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;
        sat_next   = sat_reg;
        wrap_evt   = 1'b0;
        if (load) begin
            count_next = (load_val > limit_reg) ? limit_reg : load_val;
            sat_next   = 1'b0;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (count_reg < limit_reg) begin
                    count_next = count_reg + WIDTH'(1);
                    sat_next   = 1'b0;
                end else if (mode == MODE_WRAP) begin
                    count_next = '0;
                    wrap_evt   = 1'b1;
                    sat_next   = 1'b0;
                end else begin
                    count_next = limit_reg;
                    sat_next   = 1'b1;
                end
            end else begin
                if (count_reg > limit_reg) begin
                    count_next = limit_reg;
                    sat_next   = 1'b0;
                end else if (count_reg != '0) begin
                    count_next = count_reg - WIDTH'(1);
                    sat_next   = 1'b0;
                end else if (mode == MODE_WRAP) begin
                    count_next = limit_reg;
                    wrap_evt   = 1'b1;
                    sat_next   = 1'b0;
                end else begin
                    sat_next   = 1'b1;
                end
            end
            tc_next = wrap_evt;
        end
        // Saturation is only meaningful in saturate mode.
        if (mode == MODE_WRAP) begin
            sat_next = 1'b0;
        end
    end

    assign count = count_reg;
    assign tc    = tc_reg;
    assign sat   = sat_reg;

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH programmable modulo counters with optional cascading:
// a chained channel steps only when its lower neighbour wraps.
module multi_channel_counter
    import counter_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 8,
    parameter int DEFAULT_LIMIT = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             en,
    input  logic [NUM_CH-1:0]             up_dn,
    input  logic [NUM_CH-1:0]             sat_mode,
    input  logic [NUM_CH-1:0]             chain,
    input  logic                          load,
    input  logic [ch_width(NUM_CH)-1:0]   load_ch,
    input  logic [WIDTH-1:0]              load_val,
    input  logic                          limit_we,
    input  logic [ch_width(NUM_CH)-1:0]   limit_ch,
    input  logic [WIDTH-1:0]              limit_val,
    output logic [NUM_CH*WIDTH-1:0]       count,
    output logic [NUM_CH-1:0]             tc,
    output logic [NUM_CH-1:0]             sat
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] wrap_evt;
    logic [NUM_CH-1:0] load_sel;
    logic [NUM_CH-1:0] limit_sel;

    // chain[0] has no lower neighbour to follow.
    logic unused_chain0;
    assign unused_chain0 = chain[0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Out-of-range channel indices match no channel and are dropped.
            assign load_sel[gi]  = load     && (load_ch  == CH_W'(gi));
            assign limit_sel[gi] = limit_we && (limit_ch == CH_W'(gi));

            if (gi == 0) begin : g_first
                assign step[gi] = en[gi];
            end else begin : g_rest
                assign step[gi] = en[gi] & (chain[gi] ? wrap_evt[gi-1] : 1'b1);
            end

            counter_channel #(
                .WIDTH         (WIDTH),
                .DEFAULT_LIMIT (DEFAULT_LIMIT)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .step      (step[gi]),
                .dir       (count_dir_e'(up_dn[gi])),
                .mode      (count_mode_e'(sat_mode[gi])),
                .load      (load_sel[gi]),
                .load_val  (load_val),
                .limit_we  (limit_sel[gi]),
                .limit_val (limit_val),
                .count     (count[gi*WIDTH +: WIDTH]),
                .tc        (tc[gi]),
                .sat       (sat[gi]),
                .wrap_evt  (wrap_evt[gi])
            );
        end
    endgenerate

endmodule

// File: doc/multi_channel_counter.md
Name: multi_channel_counter

Overview:
Bank of NUM_CH independent modulo counters. Each channel has a runtime-programmable limit, an up/down direction, and a choice of wrap or saturate mode. Channels support a synchronous load, a one-cycle terminal-count pulse, and optional cascading, where channel i steps on the wrap of channel i-1. Generalised successor of the fixed two-channel, fixed-limit counter; used for timers, prescalers and multi-digit counting.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
WIDTH, 8, counter and limit width in bits
DEFAULT_LIMIT, 10, per-channel limit after reset (must be < 2**WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  NUM_CH  per-channel count enable
up_dn  input  NUM_CH  per-channel direction: 1 = up, 0 = down
sat_mode  input  NUM_CH  per-channel mode: 0 = wrap, 1 = saturate
chain  input  NUM_CH  1 = channel i steps on wrap of channel i-1; bit 0 ignored
load  input  1  load strobe
load_ch  input  CH_W  channel to load; CH_W = max(1, $clog2(NUM_CH))
load_val  input  WIDTH  load value
limit_we  input  1  limit write strobe
limit_ch  input  CH_W  channel whose limit is written
limit_val  input  WIDTH  new limit value
count  output  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
tc  output  NUM_CH  terminal-count pulse, one cycle per wrap
sat  output  NUM_CH  high while the channel is held at a bound in saturate mode

Behaviour:
- Reset values: count = 0; limit = DEFAULT_LIMIT; tc = 0; sat = 0 for all channels. Reset overrides every other input.
- Count range is 0..limit inclusive; the channel has limit+1 states. limit = 0 keeps count at 0 and wraps on every step.
- Step condition:
  - Channel 0: step = en.
  - Channel i > 0: step = en[i] & (chain[i] ? wrap_evt[i-1] : 1).
  - wrap_evt[i] is combinational, asserted when the channel steps at its terminal value in wrap mode. A cascade ripples within the same cycle; there are no combinational loops.
- Up step:
  - count < limit: count + 1.
  - count >= limit, wrap mode: count becomes 0 and tc pulses.
  - count >= limit, saturate mode: count becomes limit and sat is set.
- Down step:
  - 0 < count <= limit: count - 1.
  - count > limit: count becomes limit, no tc.
  - count == 0, wrap mode: count becomes limit and tc pulses.
  - count == 0, saturate mode: count holds and sat is set.
- tc is registered. It is high in exactly the cycle in which the wrapped value first appears on count.
- sat is registered. It clears on any count change, load, or mode change to wrap. It stays set while stepping against the bound.
- Load (load = 1, load_ch = i):
  - count[i] = min(load_val, current limit[i]).
  - Load has priority over a step in the same cycle.
  - tc[i] = 0 and sat[i] = 0 next cycle.
  - Loaded channel produces no wrap_evt that cycle.
- Limit write: limit[limit_ch] = limit_val, visible from the next cycle. A same-cycle load on the same channel clamps against the old limit.
- An out-of-range load_ch or limit_ch (>= NUM_CH) is ignored.
- A disabled channel holds count; tc = 0; sat is held.
- No arithmetic overflow modulo 2**WIDTH can occur, because count is always bounded by limit.

Decomposition:
- Package counter_pkg:
  - count_mode_e {MODE_WRAP, MODE_SAT}
  - count_dir_e {DIR_DOWN, DIR_UP}
  - function ch_width(n) returning max(1, $clog2(n))
- Sub-module counter_channel:
  - Holds one count, limit, tc and sat register.
  - Inputs: step, dir, mode, load, load_val, limit_we, limit_val.
  - Output: wrap_evt.
- The top level instantiates counter_channel NUM_CH times in a generate loop, plus channel-select decode and chain wiring.

Test Plan:
- Reset, then en[0] = 1, up, wrap, limit 10, for 12 cycles -> count0 goes 1..10, 0, 1; tc[0] high only in the cycle count0 = 0.
- Channel 1 down, saturate, count 2, for 4 cycles -> 1, 0, 0, 0; sat[1] high from the second 0; then load 5 -> count1 = 5, sat[1] = 0.
- chain[1] = 1, channel 0 limit 3 up, channel 1 limit 2 up, 12 cycles -> count1 increments in the same cycle count0 wraps to 0; after 12 steps count1 = 0 and tc[1] pulses once.
- With count2 = 9, write limit2 = 4 then one up step -> wrap mode: count2 = 0 with tc; saturate mode: count2 = 4 with sat.
- Same cycle: load ch3 = 200 with limit 10, en[3] = 1, limit write ch3 = 250 -> count3 = 10 (old limit clamps), limit3 = 250 next cycle, no tc.
- Assert rst mid-count with load and limit_we active -> all counts 0, limits = 10, tc = 0, sat = 0 next cycle.
